div_nonrestoring: RTL and testbench
===================================

Name: div_nonrestoring

Overview:
- Iterative 32-bit signed integer divider; the inverse operation of the team's radix-4 Booth multiplier step in the multdiv unit.
- Produces one quotient bit per clock using non-restoring division over a {remainder, quotient} shift register.
- Reports quotient and remainder, with a one-cycle ready pulse and a divide-by-zero exception.
- Sits beside the multiplier under multdiv and is driven by the same start/ready handshake from the processor pipeline stall logic.

Parameters:
- WIDTH, 32, operand/result width in bits; counter width is clog2(WIDTH).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_div  input  1  start pulse; operands are sampled on the edge where ctrl_div=1.
- data_operandA  input  WIDTH  signed dividend.
- data_operandB  input  WIDTH  signed divisor.
- data_result  output  WIDTH  signed quotient.
- data_remainder  output  WIDTH  signed remainder; its sign follows the dividend.
- data_exception  output  1  high with ready when the divisor is 0.
- data_resultRDY  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - data_result, data_remainder, data_exception and data_resultRDY all go to 0.
  - Internal 65-bit A:Q register and counter clear to 0.
  - Reset mid-operation abandons the divide; no ready pulse follows.
- States: IDLE, RUN, FIX, DONE.
  - IDLE, ctrl_div=1 at edge E:
    - Latch |A| into Q, |B| into M, A:=0, count:=0.
    - Latch sign_q = A[msb]^B[msb] and sign_r = A[msb].
    - If B==0, go to DONE with zero flag set; otherwise go to RUN.
  - RUN, one iteration per edge, 32 edges (E+1..E+32):
    - Shift {A,Q} left by 1.
    - If old A >= 0 then A := A - M, else A := A + M.
    - Q[0] := ~A_new[32].
    - count++; after count==WIDTH-1, go to FIX.
  - FIX, edge E+33:
    - If A < 0, A := A + M.
    - Apply signs: quotient = sign_q ? -Q : Q; remainder = sign_r ? -A[31:0] : A[31:0].
    - Load both outputs; go to DONE.
  - DONE:
    - data_resultRDY=1 for exactly one cycle.
    - Normal divide: RDY is high for the cycle after edge E+34.
    - Divide-by-zero: RDY is high for the cycle after edge E+1, with data_result=0, data_remainder=0, data_exception=1.
    - Next edge returns to IDLE.
- Output holding: data_result, data_remainder and data_exception hold their values until the next completion or reset. data_exception clears on the next start.
- Arithmetic width rules:
  - Adder/subtractor is 33 bits wide; magnitudes are unsigned 32-bit, so |INT_MIN| = 0x80000000 is handled exactly.
  - Negation is two's complement modulo 2^32.
  - INT_MIN / -1 gives 0x80000000 with remainder 0 and data_exception=0 (wraps, no exception).
- Start while busy: ctrl_div=1 in RUN or FIX aborts the current divide and restarts with the new operands as at edge E. No ready pulse is produced for the aborted divide.
- Start in DONE: accepted. RDY still pulses that cycle for the old result.
- Latency: 34 cycles for a normal divide, 1 cycle for divide-by-zero. Throughput is one divide in flight.

Decomposition:
- Shared multdiv package holds:
  - state encodings IDLE/RUN/FIX/DONE (2-bit);
  - WIDTH default;
  - count width constant.
- Sub-module div_step (combinational):
  - Takes {A,Q}, M.
  - Returns the shifted-and-added/subtracted {A,Q} with the new quotient bit.
  - Uses the existing 32-bit adder extended with a sign bit.
- FSM, counter, sign fix-up and output registers stay in div_nonrestoring.

Test Plan:
- 100 / 7, start at E → RDY high only in the cycle after E+34; result=14, remainder=2, exception=0.
- -100 / 7 → result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); 100 / -7 → result=-14, remainder=2.
- 7 / 0 → RDY in the cycle after E+1; result=0, remainder=0, exception=1. A following 9 / 3 → result=3, exception=0.
- 0x80000000 / 0xFFFFFFFF → result=0x80000000, remainder=0, exception=0. 0x80000000 / 2 → result=0xC0000000.
- Start 100/7 at E, then start 50/5 at E+10 → no RDY before E+44; RDY in the cycle after E+44 with result=10, remainder=0.
- Start 100/7, assert reset_n=0 at E+20 for 2 cycles → outputs 0 immediately (async) and no RDY. A restart of 21/4 then completes at +34 with result=5, remainder=1.

Source files
------------

// File: rtl/div_nonrestoring_pkg.sv
// Shared multdiv definitions for the iterative divider.
// State encodings, default width and counter width.
package div_nonrestoring_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CW    = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_nonrestoring_step.sv
// One non-restoring iteration over the {A,Q} shift register.
// A is WIDTH+1 bits so |INT_MIN| magnitudes stay exact.
module div_step
    import div_nonrestoring_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH:0]  aq,
    input  logic [WIDTH-1:0]  m,
    output logic [2*WIDTH:0]  aq_next
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] a_new;

    // Shifting drops old A's top bit; its sign still picks add vs sub.
    assign a_sh  = aq[2*WIDTH-1:WIDTH-1];
    assign m_ext = {1'b0, m};
    assign a_new = aq[2*WIDTH] ? (a_sh + m_ext)
                               : (a_sh - m_ext);

    assign aq_next = {a_new, aq[WIDTH-2:0], ~a_new[WIDTH]};

endmodule

// File: rtl/div_nonrestoring.sv
// Iterative signed non-restoring divider, one quotient bit per clock.
// Start/ready handshake shared with the multiplier under multdiv.
module div_nonrestoring
    import div_nonrestoring_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [2*WIDTH:0] aq;
    logic [2*WIDTH:0] aq_next;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic             b_zero;

    assign a_mag  = data_operandA[WIDTH-1] ? -data_operandA
                                           : data_operandA;
    assign b_mag  = data_operandB[WIDTH-1] ? -data_operandB
                                           : data_operandB;
    assign b_zero = (data_operandB == '0);

    // Final restore: the true remainder lies in [0, M), so mod-2^W is exact.
    assign q_mag = aq[WIDTH-1:0];
    assign r_mag = aq[2*WIDTH] ? (aq[2*WIDTH-1:WIDTH] + m)
                               : aq[2*WIDTH-1:WIDTH];

    div_step #(.WIDTH(WIDTH)) u_step (
        .aq      (aq),
        .m       (m),
        .aq_next (aq_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            aq             <= '0;
            m              <= '0;
            count          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            zero           <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            // A start in DONE still reports the finishing divide.
            if (state == S_DONE) begin
                data_resultRDY <= 1'b1;
                if (zero) begin
                    data_result    <= '0;
                    data_remainder <= '0;
                    data_exception <= 1'b1;
                end
            end
            if (ctrl_div) begin
                aq     <= {{(WIDTH+1){1'b0}}, a_mag};
                m      <= b_mag;
                count  <= '0;
                sign_q <= data_operandA[WIDTH-1]
                        ^ data_operandB[WIDTH-1];
                sign_r <= data_operandA[WIDTH-1];
                zero   <= b_zero;
                state  <= b_zero ? S_DONE : S_RUN;
                if (state != S_DONE) begin
                    data_exception <= 1'b0;
                end
            end else begin
                unique case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_RUN: begin
                        aq    <= aq_next;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        data_result    <= sign_q ? -q_mag : q_mag;
                        data_remainder <= sign_r ? -r_mag : r_mag;
                        state          <= S_DONE;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_nonrestoring.sv
// Directed and random checks of div_nonrestoring against
// a plain-arithmetic signed division model.
module tb_div_nonrestoring;

    logic        clock;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    div_nonrestoring dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truncating signed division; remainder takes the dividend's sign.
    task automatic model(input  logic [31:0] a,
                         input  logic [31:0] b,
                         output logic [31:0] q,
                         output logic [31:0] r,
                         output logic        e);
        longint la;
        longint lb;
        longint lq;
        longint lr;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (lb == 0) begin
            q = 32'd0;
            r = 32'd0;
            e = 1'b1;
        end else begin
            lq = la / lb;
            lr = la - lq * lb;
            q  = lq[31:0];
            r  = lr[31:0];
            e  = 1'b0;
        end
    endtask

    // Called #1 after a posedge; the following edge samples the start.
    task automatic start(input logic [31:0] a,
                         input logic [31:0] b);
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
    endtask

    task automatic wait_rdy(input string tag, input int lat);
        int seen;
        seen = -1;
        // The loop runs from the edge after E; RDY sampled #1 later.
        for (int k = 1; k <= 60; k++) begin
            if (seen < 0) begin
                @(posedge clock);
                #1;
                if (data_resultRDY) seen = k;
            end
        end
        check({tag, " latency"}, 64'(seen), 64'(lat));
    endtask

    task automatic run_div(input string tag,
                           input logic [31:0] a,
                           input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        model(a, b, q, r, e);
        start(a, b);
        wait_rdy(tag, e ? 1 : 34);
        check({tag, " result"}, 64'(data_result), 64'(q));
        check({tag, " remainder"}, 64'(data_remainder), 64'(r));
        check({tag, " exception"}, 64'(data_exception), 64'(e));
        @(posedge clock);
        #1;
        check({tag, " pulse"}, 64'(data_resultRDY), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          saw;

        reset_n       = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset result", 64'(data_result), 64'd0);
        check("reset remainder", 64'(data_remainder), 64'd0);
        check("reset exception", 64'(data_exception), 64'd0);
        check("reset rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_div("100/7", 32'd100, 32'd7);
        run_div("-100/7", -32'sd100, 32'd7);
        run_div("100/-7", 32'd100, -32'sd7);
        run_div("-100/-7", -32'sd100, -32'sd7);
        run_div("7/0", 32'd7, 32'd0);
        run_div("9/3", 32'd9, 32'd3);
        run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("min/2", 32'h8000_0000, 32'd2);
        run_div("min/min", 32'h8000_0000, 32'h8000_0000);
        run_div("5/min", 32'd5, 32'h8000_0000);
        run_div("max/1", 32'h7FFF_FFFF, 32'd1);

        // Restart mid-divide: only the second divide completes.
        start(32'd100, 32'd7);
        saw = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) saw++;
        end
        check("abort no rdy", 64'(saw), 64'd0);
        start(32'd50, 32'd5);
        wait_rdy("restart", 34);
        check("restart result", 64'(data_result), 64'd10);
        check("restart remainder", 64'(data_remainder), 64'd0);
        @(posedge clock);
        #1;

        // Async reset mid-divide clears outputs at once.
        start(32'd100, 32'd7);
        repeat (19) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async result", 64'(data_result), 64'd0);
        check("async remainder", 64'(data_remainder), 64'd0);
        saw = 0;
        repeat (2) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) saw++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) saw++;
        end
        check("reset no rdy", 64'(saw), 64'd0);
        run_div("21/4", 32'd21, 32'd4);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(1, 15);
                1:       rb = -($urandom_range(1, 15));
                2:       rb = (i % 6 == 0) ? 32'd0 : $urandom;
                default: rb = $urandom >> $urandom_range(0, 30);
            endcase
            run_div($sformatf("rand%0d", i), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
